branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequencer for the ID-stage branch comparator (32-bit rs/rt equality unit, 3-bit control; BEQ=1, BNE=6, any other code forces result 0).
- Holds a decoded branch in ID while its operands are still being produced, then drives the comparator control for exactly one cycle.
- Samples the comparator result and issues a registered PC redirect plus an IF/ID flush for taken branches.
- Sits between the ID decoder/hazard unit and the PC/IF-ID pipeline registers.

Parameters:
- ADDR_W, 32, width of the branch target and redirect PC
- MAX_WAIT, 3, maximum consecutive operand-wait cycles before HazardTimeout is raised

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- BranchValid  in  1  instruction in IF/ID is a candidate branch
- BranchOp  in  3  branch control code from decode
- OpndHazard  in  1  rs or rt not yet available (ALU result in EX, or load in EX/MEM)
- Target  in  ADDR_W  computed branch target, valid with BranchValid
- CmpResult  in  1  comparator Result
- CmpControl  out  3  comparator Control
- Stall  out  1  hold PC and IF/ID, bubble ID/EX
- Redirect  out  1  load PC from RedirectPC
- RedirectPC  out  ADDR_W  registered target
- Flush  out  1  zero IF/ID at next edge
- HazardTimeout  out  1  sticky error flag
- Busy  out  1  state is not IDLE

Behaviour:
- Reset (async, Rst_n=0): state=IDLE, RedirectPC=0, Redirect=0, Flush=0, HazardTimeout=0, wait counter=0. CmpControl=0 and Stall=0 while in reset.
- Br = BranchValid & (BranchOp==BEQ | BranchOp==BNE). Other codes are not branches: no stall, CmpControl=0.
- States: IDLE, WAIT, REDIRECT.
- IDLE:
  - Br & OpndHazard: Stall=1, CmpControl=0, go to WAIT, wait counter=1.
  - Br & !OpndHazard: resolve cycle. CmpControl=BranchOp (combinational), Stall=0.
    - CmpResult=1: latch Target into RedirectPC, go to REDIRECT.
    - CmpResult=0: stay in IDLE. Not-taken costs 0 cycles.
  - !Br: CmpControl=0, Stall=0.
- WAIT:
  - Stall=1 while OpndHazard.
  - Wait counter increments and saturates at MAX_WAIT+1.
  - When it reaches MAX_WAIT+1 with hazard still set, HazardTimeout sets (sticky until reset); the FSM keeps waiting.
  - When OpndHazard=0: resolve exactly as in IDLE (Stall=0 that cycle), then go to REDIRECT if taken, else IDLE. Counter clears.
- REDIRECT (one cycle):
  - Redirect=1, Flush=1, Stall=0, CmpControl=0.
  - BranchValid is ignored (wrong-path instruction).
  - Always returns to IDLE. Taken penalty is 1 bubble.
- Redirect and Flush are registered Moore outputs; they are never asserted outside REDIRECT.
- Back-to-back: a branch arriving in IF/ID the cycle after REDIRECT is handled normally from IDLE.
- BranchOp change during WAIT: the value present at the resolve cycle is used; decode holds IF/ID stable under Stall.
- Reset mid-WAIT or mid-REDIRECT: immediate return to IDLE; any pending redirect is dropped.
- Busy = (state != IDLE).

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds three 32-bit wrapping counters: TakenCnt, NotTakenCnt, StallCnt (stall cycles spent in WAIT plus the IDLE entry cycle).
  - Exported as output ports of those names; reset to 0 asynchronously.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package (branch_pkg):
  - branch codes BEQ=3'd1, BNE=3'd6, CMP_NONE=3'd0
  - FSM state encoding IDLE=2'd0, WAIT=2'd1, REDIRECT=2'd2
- Sub-module: branch_stats_counters, instantiated only under BRANCH_STATS_EN. Inputs: taken pulse, not-taken pulse, stall pulse.

Test Plan:
- Reset: Rst_n low mid-WAIT with Target=0x100 -> all outputs 0 asynchronously, state IDLE, no Redirect after release.
- Not-taken fast path: Br BEQ, OpndHazard=0, CmpResult=0 -> CmpControl=1 for one cycle, Stall=0, Redirect never set.
- Taken fast path: Br BNE, Target=0x0000_0040, CmpResult=1 -> CmpControl=6 in cycle N; Redirect=1, Flush=1, RedirectPC=0x40 in cycle N+1; IDLE in N+2.
- Load-use wait: OpndHazard high for 2 cycles, then BEQ taken -> Stall=1 for 2 cycles, resolve in cycle 3, Redirect in cycle 4, HazardTimeout=0.
- Timeout: OpndHazard held 5 cycles (MAX_WAIT=3) -> HazardTimeout rises after the 4th wait cycle and stays 1 after the branch resolves.
- Stats (BRANCH_STATS_EN): 3 taken, 2 not-taken, 4 stall cycles -> TakenCnt=3, NotTakenCnt=2, StallCnt=4. Non-branch BranchOp=3'd2 with BranchValid leaves all counters unchanged.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: comparator control codes, FSM state encoding and branch decode helper.
package branch_pkg;
  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] BEQ = 3'd1;
  localparam logic [2:0] BNE = 3'd6;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, REDIRECT = 2'd2} state_t;
  function automatic logic is_br(input logic [2:0] op);
    return (op == BEQ) || (op == BNE);
  endfunction
endpackage

// File: rtl/branch_stats_counters.sv
// branch_stats_counters: wrapping taken / not-taken / stall-cycle event counters.
module branch_stats_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        taken,
  input  logic        not_taken,
  input  logic        stall,
  output logic [31:0] taken_cnt,
  output logic [31:0] not_taken_cnt,
  output logic [31:0] stall_cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= '0;
      not_taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      taken_cnt <= taken_cnt + {31'd0, taken};
      not_taken_cnt <= not_taken_cnt + {31'd0, not_taken};
      stall_cnt <= stall_cnt + {31'd0, stall};
    end
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch sequencer (operand wait, one-cycle compare, registered redirect).
// Optional BRANCH_STATS_EN adds TakenCnt/NotTakenCnt/StallCnt outputs.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              BranchValid,
  input  logic [2:0]        BranchOp,
  input  logic              OpndHazard,
  input  logic [ADDR_W-1:0] Target,
  input  logic              CmpResult,
  output logic [2:0]        CmpControl,
  output logic              Stall,
  output logic              Redirect,
  output logic [ADDR_W-1:0] RedirectPC,
  output logic              Flush,
  output logic              HazardTimeout,
  output logic              Busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       TakenCnt,
  output logic [31:0]       NotTakenCnt,
  output logic [31:0]       StallCnt
`endif
);
  localparam int CW = $clog2(MAX_WAIT + 2);
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT + 1);
  state_t state;
  logic [CW-1:0] wcnt;
  logic active, resolve, taken;
  // a branch is "active" in IDLE only when decoded; in WAIT IF/ID is held so it stays active
  assign active = Rst_n & ((state == WAIT) | ((state == IDLE) & BranchValid & is_br(BranchOp)));
  assign resolve = active & ~OpndHazard;
  assign Stall = active & OpndHazard;
  assign taken = resolve & CmpResult;
  assign CmpControl = resolve ? BranchOp : CMP_NONE;
  assign Busy = state != IDLE;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      RedirectPC <= '0;
      Redirect <= 1'b0;
      Flush <= 1'b0;
      HazardTimeout <= 1'b0;
    end else begin
      Redirect <= taken;
      Flush <= taken;
      if (taken) RedirectPC <= Target;
      case (state)
        IDLE: begin
          if (Stall) begin
            state <= WAIT;
            wcnt <= CW'(1);
          end else if (taken) state <= REDIRECT;
        end
        WAIT: begin
          if (OpndHazard) begin
            wcnt <= (wcnt == CMAX) ? CMAX : wcnt + CW'(1);
            if (wcnt >= CMAX - CW'(1)) HazardTimeout <= 1'b1;
          end else begin
            wcnt <= '0;
            state <= taken ? REDIRECT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BRANCH_STATS_EN
  branch_stats_counters u_stats (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .taken        (taken),
    .not_taken    (resolve & ~CmpResult),
    .stall        (Stall),
    .taken_cnt    (TakenCnt),
    .not_taken_cnt(NotTakenCnt),
    .stall_cnt    (StallCnt)
  );
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed-vector bench for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        BranchValid = 1'b0;
  logic [2:0]  BranchOp = 3'd0;
  logic        OpndHazard = 1'b0;
  logic [31:0] Target = 32'd0;
  logic        CmpResult = 1'b0;
  logic [2:0]  CmpControl;
  logic        Stall, Redirect, Flush, HazardTimeout, Busy;
  logic [31:0] RedirectPC;
`ifdef BRANCH_STATS_EN
  logic [31:0] TakenCnt, NotTakenCnt, StallCnt;
`endif
  int total = 0;
  int bad = 0;
  always #5 Clk = ~Clk;
  branch_resolve_ctrl #(.ADDR_W(32), .MAX_WAIT(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .BranchValid(BranchValid), .BranchOp(BranchOp),
    .OpndHazard(OpndHazard), .Target(Target), .CmpResult(CmpResult),
    .CmpControl(CmpControl), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .Flush(Flush), .HazardTimeout(HazardTimeout), .Busy(Busy)
`ifdef BRANCH_STATS_EN
    , .TakenCnt(TakenCnt), .NotTakenCnt(NotTakenCnt), .StallCnt(StallCnt)
`endif
  );
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] op, input logic hz, input logic [31:0] t, input logic r);
    BranchValid = v;
    BranchOp = op;
    OpndHazard = hz;
    Target = t;
    CmpResult = r;
  endtask
  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    Rst_n = 1'b0;
    #3;
    total++; if (Redirect !== 1'b0) begin bad++; $display("FAIL rst_redirect got=%0h exp=0", Redirect); end
    total++; if (Flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0h exp=0", Flush); end
    total++; if (RedirectPC !== 32'd0) begin bad++; $display("FAIL rst_pc got=%0h exp=0", RedirectPC); end
    total++; if (HazardTimeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0h exp=0", HazardTimeout); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", Busy); end
    cyc();
    Rst_n = 1'b1;
    cyc();
    drive(1, 3'd1, 1, 32'h100, 1);
    #1;
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL rst_entry_stall got=%0h exp=1", Stall); end
    cyc();
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rst_wait_busy got=%0h exp=1", Busy); end
    Rst_n = 1'b0;
    #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%0h exp=0", Busy); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL rst_async_stall got=%0h exp=0", Stall); end
    OpndHazard = 1'b0;
    #1;
    total++; if (CmpControl !== 3'd0) begin bad++; $display("FAIL rst_cmpctl got=%0h exp=0", CmpControl); end
    BranchValid = 1'b0;
    cyc();
    Rst_n = 1'b1;
    cyc();
    total++; if (Redirect !== 1'b0) begin bad++; $display("FAIL rst_release_redirect got=%0h exp=0", Redirect); end
    total++; if (RedirectPC !== 32'd0) begin bad++; $display("FAIL rst_release_pc got=%0h exp=0", RedirectPC); end
  endtask
  task automatic test_not_taken();
    drive(1, 3'd1, 0, 32'h44, 0);
    #1;
    total++; if (CmpControl !== 3'd1) begin bad++; $display("FAIL nt_cmpctl got=%0h exp=1", CmpControl); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL nt_stall got=%0h exp=0", Stall); end
    cyc();
    drive(0, 0, 0, 0, 0);
    #1;
    total++; if (CmpControl !== 3'd0) begin bad++; $display("FAIL nt_cmpctl_after got=%0h exp=0", CmpControl); end
    total++; if (Redirect !== 1'b0) begin bad++; $display("FAIL nt_redirect got=%0h exp=0", Redirect); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL nt_busy got=%0h exp=0", Busy); end
  endtask
  task automatic test_taken();
    drive(1, 3'd6, 0, 32'h40, 1);
    #1;
    total++; if (CmpControl !== 3'd6) begin bad++; $display("FAIL tk_cmpctl got=%0h exp=6", CmpControl); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL tk_stall got=%0h exp=0", Stall); end
    cyc();
    drive(1, 3'd1, 0, 32'h99, 1);
    #1;
    total++; if (Redirect !== 1'b1) begin bad++; $display("FAIL tk_redirect got=%0h exp=1", Redirect); end
    total++; if (Flush !== 1'b1) begin bad++; $display("FAIL tk_flush got=%0h exp=1", Flush); end
    total++; if (RedirectPC !== 32'h40) begin bad++; $display("FAIL tk_pc got=%0h exp=40", RedirectPC); end
    total++; if (CmpControl !== 3'd0) begin bad++; $display("FAIL tk_wrongpath_cmpctl got=%0h exp=0", CmpControl); end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL tk_busy got=%0h exp=1", Busy); end
    drive(0, 0, 0, 0, 0);
    cyc();
    total++; if (Redirect !== 1'b0) begin bad++; $display("FAIL tk_redirect_clr got=%0h exp=0", Redirect); end
    total++; if (Flush !== 1'b0) begin bad++; $display("FAIL tk_flush_clr got=%0h exp=0", Flush); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL tk_idle got=%0h exp=0", Busy); end
  endtask
  task automatic test_load_use();
    drive(1, 3'd1, 1, 32'h80, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (Stall !== 1'b1) begin bad++; $display("FAIL lu_stall%0d got=%0h exp=1", i, Stall); end
      total++; if (CmpControl !== 3'd0) begin bad++; $display("FAIL lu_cmpctl%0d got=%0h exp=0", i, CmpControl); end
      cyc();
    end
    OpndHazard = 1'b0;
    CmpResult = 1'b1;
    #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL lu_resolve_stall got=%0h exp=0", Stall); end
    total++; if (CmpControl !== 3'd1) begin bad++; $display("FAIL lu_resolve_cmpctl got=%0h exp=1", CmpControl); end
    cyc();
    drive(0, 0, 0, 0, 0);
    #1;
    total++; if (Redirect !== 1'b1) begin bad++; $display("FAIL lu_redirect got=%0h exp=1", Redirect); end
    total++; if (RedirectPC !== 32'h80) begin bad++; $display("FAIL lu_pc got=%0h exp=80", RedirectPC); end
    total++; if (HazardTimeout !== 1'b0) begin bad++; $display("FAIL lu_timeout got=%0h exp=0", HazardTimeout); end
    cyc();
  endtask
  task automatic test_timeout();
    drive(1, 3'd1, 1, 32'h200, 0);
    for (int i = 1; i <= 5; i++) begin
      #1;
      total++; if (Stall !== 1'b1) begin bad++; $display("FAIL to_stall%0d got=%0h exp=1", i, Stall); end
      total++; if (HazardTimeout !== (i >= 5)) begin bad++; $display("FAIL to_flag%0d got=%0h exp=%0h", i, HazardTimeout, i >= 5); end
      cyc();
    end
    drive(1, 3'd6, 0, 32'h200, 0);
    #1;
    total++; if (CmpControl !== 3'd6) begin bad++; $display("FAIL to_cmpctl got=%0h exp=6", CmpControl); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL to_resolve_stall got=%0h exp=0", Stall); end
    cyc();
    drive(0, 0, 0, 0, 0);
    #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%0h exp=0", Busy); end
    total++; if (Redirect !== 1'b0) begin bad++; $display("FAIL to_redirect got=%0h exp=0", Redirect); end
    total++; if (HazardTimeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0h exp=1", HazardTimeout); end
    cyc();
  endtask
  task automatic test_back_to_back();
    drive(1, 3'd1, 0, 32'h10, 1);
    cyc();
    drive(1, 3'd6, 0, 32'h20, 1);
    #1;
    total++; if (RedirectPC !== 32'h10) begin bad++; $display("FAIL b2b_pc1 got=%0h exp=10", RedirectPC); end
    total++; if (CmpControl !== 3'd0) begin bad++; $display("FAIL b2b_ignored got=%0h exp=0", CmpControl); end
    cyc();
    total++; if (CmpControl !== 3'd6) begin bad++; $display("FAIL b2b_cmpctl got=%0h exp=6", CmpControl); end
    total++; if (Redirect !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%0h exp=0", Redirect); end
    cyc();
    drive(0, 0, 0, 0, 0);
    #1;
    total++; if (Redirect !== 1'b1) begin bad++; $display("FAIL b2b_redirect2 got=%0h exp=1", Redirect); end
    total++; if (RedirectPC !== 32'h20) begin bad++; $display("FAIL b2b_pc2 got=%0h exp=20", RedirectPC); end
    cyc();
  endtask
  task automatic test_non_branch();
    drive(1, 3'd2, 1, 32'h300, 1);
    #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL nb_stall got=%0h exp=0", Stall); end
    total++; if (CmpControl !== 3'd0) begin bad++; $display("FAIL nb_cmpctl got=%0h exp=0", CmpControl); end
    cyc();
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL nb_busy got=%0h exp=0", Busy); end
    drive(0, 0, 0, 0, 0);
    cyc();
    total++; if (Redirect !== 1'b0) begin bad++; $display("FAIL nb_redirect got=%0h exp=0", Redirect); end
  endtask
`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    Rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    cyc();
    Rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd1, 0, 32'h500, 1);
      cyc();
      drive(0, 0, 0, 0, 0);
      cyc();
    end
    drive(1, 3'd6, 0, 32'h600, 0);
    cyc();
    drive(1, 3'd1, 1, 32'h700, 0);
    repeat (4) cyc();
    OpndHazard = 1'b0;
    cyc();
    drive(1, 3'd2, 1, 32'h800, 1);
    repeat (2) cyc();
    drive(0, 0, 0, 0, 0);
    cyc();
    total++; if (TakenCnt !== 32'd3) begin bad++; $display("FAIL st_taken got=%0d exp=3", TakenCnt); end
    total++; if (NotTakenCnt !== 32'd2) begin bad++; $display("FAIL st_nottaken got=%0d exp=2", NotTakenCnt); end
    total++; if (StallCnt !== 32'd4) begin bad++; $display("FAIL st_stall got=%0d exp=4", StallCnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_not_taken();
    test_taken();
    test_load_use();
    test_timeout();
    test_back_to_back();
    test_non_branch();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
